ref_mem_loader: RTL and testbench
=================================

Name: ref_mem_loader

Overview:
- Write-side controller for the 32-bank reference pixel memory.
- Accepts a raster stream of reference-window rows, 32 pixels per beat, from the external fetch path over a valid/ready handshake.
- Produces the memory write bus: ref_input, Bank_sel and write_address_all.
- Signals when the whole search window is resident, so the read sequencer can start 8-row reads.

Parameters:
PIXEL, 8, bits per pixel
BANKS, 32, number of memory banks; one row-beat is written to exactly one bank
ADDR_W, 7, per-bank address width (128 entries per bank)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
start  input  1  one-cycle pulse; latches cfg_rows and cfg_cols and begins a window load
cfg_rows  input  8  window height in rows, legal 1..255
cfg_cols  input  3  beats per row, legal 1..4
pix_data  input  BANKS*PIXEL  one row-beat of 32 pixels, pixel 0 in the LSBs
pix_valid  input  1  pix_data valid
pix_last  input  1  marks the final beat the source will send for this window
pix_ready  output  1  loader accepts a beat this cycle
ref_input  output  BANKS*PIXEL  write data to the memory
Bank_sel  output  BANKS  one-hot bank write enable
write_address_all  output  BANKS*ADDR_W  per-bank write address
busy  output  1  load in progress
win_done  output  1  one-cycle pulse when the window is fully written
cfg_err  output  1  sticky; set when a start carries an illegal configuration

Behaviour:
- Reset values: pix_ready=0, Bank_sel=0, ref_input=0, write_address_all=0, busy=0, win_done=0, cfg_err=0. Internal row/col counters=0. FSM=IDLE.
- Reset mid-load aborts immediately. No win_done is issued, and outputs return to reset values on the next edge.
- FSM states: IDLE, LOAD, PAD (PAD only exists with the optional feature), DONE.
- IDLE:
  - On start, check the configuration. It is illegal if cfg_rows=0, cfg_cols=0, cfg_cols>4, or ceil(cfg_rows/32)*cfg_cols>128.
  - Illegal: set cfg_err and stay in IDLE.
  - Legal: clear cfg_err, latch the configuration, go to LOAD, busy=1.
  - start while busy is ignored.
- LOAD:
  - pix_ready=1. A beat transfers when pix_valid and pix_ready are both 1.
  - For accepted beat (row r, col c): bank = r mod 32, addr = (r div 32)*cfg_cols + c.
  - Write registered, latency 1: on the next cycle Bank_sel = 1<<bank, ref_input = pix_data, and all 32 fields of write_address_all = addr.
  - On cycles with no transfer, Bank_sel=0; ref_input and write_address_all hold their previous values.
  - Counter order: c counts 0..cfg_cols-1, then wraps to 0 with r+1.
  - After the beat with r=cfg_rows-1 and c=cfg_cols-1 is accepted, go to DONE and drop pix_ready on that same edge.
- pix_last in LOAD:
  - pix_last on the final counted beat: normal completion.
  - pix_last early (without the feature): go to DONE with the remaining entries left unwritten.
  - Beats offered after the window count is reached are not accepted (pix_ready=0).
- DONE:
  - Lasts one cycle. This is the cycle in which the last Bank_sel write is visible.
  - On the following cycle win_done=1 for exactly one cycle and busy=0, and the FSM returns to IDLE.
  - A start coincident with win_done is accepted.

Optional Feature:
- Macro: REF_LOADER_PAD_EN.
- With the macro defined, an early pix_last moves the FSM to PAD after the last real beat.
- PAD behaviour:
  - pix_ready=0.
  - Remaining rows are written by replicating the last complete row's beats. A buffer holds up to 4 beats.
  - A partial final row is first completed using its own last beat.
  - One write is issued per cycle, with bank and address computed as in LOAD.
  - After the final padded write, go to DONE.
- Without the macro, early pix_last goes straight to DONE and the PAD state and buffer are absent.

Test Plan:
- Basic load: cfg_rows=8, cfg_cols=1, 8 beats of data 0x01..0x08 replicated per pixel. Required: Bank_sel=0x1,0x2,...,0x80 on consecutive cycles, address 0, win_done exactly 2 cycles after the last accept.
- Wrap: cfg_rows=40, cfg_cols=2. Required: row 33 col 1 writes Bank_sel=0x2 at addr 3, and all 32 address fields equal 3.
- Backpressure gaps: pix_valid toggled 1,0,1,0. Required: Bank_sel=0 on idle cycles, counters unchanged, 80 writes total.
- Illegal configuration:
  - cfg_cols=5: cfg_err=1, busy stays 0.
  - A following legal start clears cfg_err.
- Reset mid-load: rst after 3 beats. Required: all outputs 0 on the next cycle and no win_done.
- Early last: cfg_rows=4, cfg_cols=1, pix_last on beat 2.
  - With REF_LOADER_PAD_EN: rows 2 and 3 are written with beat-1 data to banks 2 and 3, then win_done.
  - Without the macro: win_done follows and only banks 0 and 1 are written.

Source files
------------

// File: rtl/ref_mem_loader.sv
// rtl/ref_mem_loader.sv - write-side loader for the 32-bank reference pixel memory.
// Optional REF_LOADER_PAD_EN: pad rows after an early pix_last by replicating the last row.
module ref_mem_loader #(
  parameter int PIXEL  = 8,
  parameter int BANKS  = 32,
  parameter int ADDR_W = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              cfg_rows,
  input  logic [2:0]              cfg_cols,
  input  logic [BANKS*PIXEL-1:0]  pix_data,
  input  logic                    pix_valid,
  input  logic                    pix_last,
  output logic                    pix_ready,
  output logic [BANKS*PIXEL-1:0]  ref_input,
  output logic [BANKS-1:0]        Bank_sel,
  output logic [BANKS*ADDR_W-1:0] write_address_all,
  output logic                    busy,
  output logic                    win_done,
  output logic                    cfg_err
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int DW     = BANKS * PIXEL;

`ifdef REF_LOADER_PAD_EN
  typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
  logic [DW-1:0] r_buf [4];
`else
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

  state_t      r_state;
  logic [7:0]  r_rows;
  logic [7:0]  r_row;
  logic [2:0]  r_cols;
  logic [2:0]  r_col;

  logic [3:0]        w_ceil;
  logic [8:0]        w_need;
  logic              w_cfg_bad;
  logic [BANK_W-1:0] w_bank;
  logic [ADDR_W-1:0] w_addr;
  logic              w_col_end;
  logic              w_row_end;
  logic              w_accept;

  assign w_ceil    = 4'((9'(cfg_rows) + 9'(BANKS - 1)) >> BANK_W);
  assign w_need    = 9'(w_ceil) * 9'(cfg_cols);
  assign w_cfg_bad = (cfg_rows == 8'd0) || (cfg_cols == 3'd0) || (cfg_cols > 3'd4) ||
                     (w_need > 9'(2 ** ADDR_W));
  // Bank is the row index modulo the bank count; each wrap of 32 rows moves to the next address block.
  assign w_bank    = r_row[BANK_W-1:0];
  assign w_addr    = ADDR_W'(9'(r_row >> BANK_W) * 9'(r_cols) + 9'(r_col));
  assign w_col_end = (r_col == r_cols - 3'd1);
  assign w_row_end = (r_row == r_rows - 8'd1);
  assign w_accept  = pix_valid && pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_rows            <= '0;
      r_row             <= '0;
      r_cols            <= '0;
      r_col             <= '0;
      pix_ready         <= 1'b0;
      ref_input         <= '0;
      Bank_sel          <= '0;
      write_address_all <= '0;
      busy              <= 1'b0;
      win_done          <= 1'b0;
      cfg_err           <= 1'b0;
    end else begin
      win_done <= 1'b0;
      Bank_sel <= '0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err   <= 1'b0;
              r_rows    <= cfg_rows;
              r_cols    <= cfg_cols;
              r_row     <= '0;
              r_col     <= '0;
              busy      <= 1'b1;
              pix_ready <= 1'b1;
              r_state   <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            Bank_sel          <= BANKS'(1) << w_bank;
            ref_input         <= pix_data;
            write_address_all <= {BANKS{w_addr}};
`ifdef REF_LOADER_PAD_EN
            // Filling slots c..3 means a partial row is already completed with its last beat.
            for (int k = 0; k < 4; k++) begin
              if (3'(k) >= r_col) r_buf[k] <= pix_data;
            end
`endif
            if (w_col_end) begin
              r_col <= '0;
              r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
            if (w_col_end && w_row_end) begin
              pix_ready <= 1'b0;
              r_state   <= DONE;
            end else if (pix_last) begin
              pix_ready <= 1'b0;
`ifdef REF_LOADER_PAD_EN
              r_state   <= PAD;
`else
              r_state   <= DONE;
`endif
            end
          end
        end
`ifdef REF_LOADER_PAD_EN
        PAD: begin
          Bank_sel          <= BANKS'(1) << w_bank;
          ref_input         <= r_buf[r_col[1:0]];
          write_address_all <= {BANKS{w_addr}};
          if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + 8'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
          if (w_col_end && w_row_end) r_state <= DONE;
        end
`endif
        DONE: begin
          busy     <= 1'b0;
          win_done <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ref_mem_loader.sv
// tb/tb_ref_mem_loader.sv - scoreboard bench for ref_mem_loader.
module tb_ref_mem_loader;
  localparam int DW = 256;
  localparam int AW = 224;

  logic          clk = 1'b0;
  logic          rst, start, pix_valid, pix_last;
  logic [7:0]    cfg_rows;
  logic [2:0]    cfg_cols;
  logic [DW-1:0] pix_data;
  logic          pix_ready, busy, win_done, cfg_err;
  logic [DW-1:0] ref_input;
  logic [31:0]   Bank_sel;
  logic [AW-1:0] write_address_all;

  int compared = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int last_acc = 0;

  typedef struct {
    logic [31:0]   sel;
    logic [6:0]    addr;
    logic [DW-1:0] data;
    int            at;
    int            row;
    int            col;
  } exp_t;
  exp_t sb[$];

  ref_mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_last(pix_last), .pix_ready(pix_ready),
    .ref_input(ref_input), .Bank_sel(Bank_sel), .write_address_all(write_address_all),
    .busy(busy), .win_done(win_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int row, input int col, input int cols, input logic [DW-1:0] d,
                      input int at);
    exp_t e;
    e.sel  = 32'(1) << (row % 32);
    e.addr = 7'((row / 32) * cols + col);
    e.data = d;
    e.at   = at;
    e.row  = row;
    e.col  = col;
    sb.push_back(e);
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every nonzero Bank_sel must match the head of the scoreboard, in the cycle expected.
  always @(negedge clk) begin
    exp_t e;
    if (win_done === 1'b1) done_cnt++;
    if (Bank_sel !== 32'd0) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_write", DW'(Bank_sel), DW'(0));
      end else begin
        e = sb.pop_front();
        check("wr_sel", DW'(Bank_sel), DW'(e.sel));
        check("wr_addr", DW'(write_address_all), DW'({32{e.addr}}));
        check("wr_data", ref_input, e.data);
        check("wr_cycle", DW'(cyc), DW'(e.at));
        if (e.row == 33 && e.col == 1) begin
          check("wrap_r33c1_sel", DW'(Bank_sel), DW'(32'h2));
          check("wrap_r33c1_addr", DW'(write_address_all), DW'({32{7'd3}}));
        end
      end
    end
  end

  task automatic do_start(input logic [7:0] rows, input logic [2:0] cols);
    start = 1'b1;
    cfg_rows = rows;
    cfg_cols = cols;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last, input int row, input int col,
                      input int cols);
    int t = 0;
    pix_data  = d;
    pix_valid = 1'b1;
    pix_last  = last;
    while (pix_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (pix_ready !== 1'b1) begin
      check("ready_timeout", DW'(pix_ready), DW'(1));
    end else begin
      push(row, col, cols, d, cyc + 1);
      last_acc = cyc;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_cyc);
    int t = 0;
    while (win_done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check(tag, DW'(cyc), DW'(exp_cyc));
    check("busy_at_done", DW'(busy), DW'(0));
    check("sb_drained", DW'(sb.size()), DW'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, DW'(pix_ready), DW'(0));
    check({tag, "_sel"}, DW'(Bank_sel), DW'(0));
    check({tag, "_data"}, ref_input, DW'(0));
    check({tag, "_addr"}, DW'(write_address_all), DW'(0));
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_done"}, DW'(win_done), DW'(0));
    check({tag, "_err"}, DW'(cfg_err), DW'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    int exp_done;
    logic [DW-1:0] b0, b1;
    rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
    pix_data = '0; pix_valid = 1'b0; pix_last = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic load: 8 rows x 1 beat, banks 0..7, address 0.
    w0 = wr_cnt;
    do_start(8'd8, 3'd1);
    for (int i = 0; i < 8; i++) send({32{8'(i + 1)}}, i == 7, i, 0, 1);
    wait_done("basic_done_lat", last_acc + 2);
    check("basic_writes", DW'(wr_cnt - w0), DW'(8));
    pix_valid = 1'b1;
    pix_data = rnd();
    repeat (3) begin
      @(negedge clk);
      check("after_done_ready", DW'(pix_ready), DW'(0));
    end
    pix_valid = 1'b0;

    // Wrap: 40 rows x 2 beats; an illegal start during the load is ignored.
    w0 = wr_cnt;
    do_start(8'd40, 3'd2);
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 2; c++) begin
        if (r == 5 && c == 0) begin
          start = 1'b1;
          cfg_cols = 3'd5;
        end
        send(rnd(), (r == 39 && c == 1), r, c, 2);
        start = 1'b0;
      end
    end
    check("busy_start_err", DW'(cfg_err), DW'(0));
    wait_done("wrap_done_lat", last_acc + 2);
    check("wrap_writes", DW'(wr_cnt - w0), DW'(80));

    // Backpressure: one idle cycle between beats.
    w0 = wr_cnt;
    do_start(8'd40, 3'd2);
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 2; c++) begin
        send(rnd(), (r == 39 && c == 1), r, c, 2);
        if (!(r == 39 && c == 1)) @(negedge clk);
      end
    end
    wait_done("bp_done_lat", last_acc + 2);
    check("bp_writes", DW'(wr_cnt - w0), DW'(80));

    // Illegal configurations, then a legal start clears cfg_err.
    do_start(8'd8, 3'd5);
    @(negedge clk);
    check("ill_cols5_err", DW'(cfg_err), DW'(1));
    check("ill_cols5_busy", DW'(busy), DW'(0));
    do_start(8'd0, 3'd1);
    @(negedge clk);
    check("ill_rows0_err", DW'(cfg_err), DW'(1));
    check("ill_rows0_ready", DW'(pix_ready), DW'(0));
    do_start(8'd4, 3'd1);
    check("legal_clears_err", DW'(cfg_err), DW'(0));
    check("legal_busy", DW'(busy), DW'(1));
    for (int i = 0; i < 4; i++) send(rnd(), i == 3, i, 0, 1);
    wait_done("legal_done_lat", last_acc + 2);

    // Reset mid-load after 3 beats.
    do_start(8'd8, 3'd1);
    for (int i = 0; i < 3; i++) send(rnd(), 1'b0, i, 0, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_done", DW'(done_cnt), DW'(d0));
    check("midrst_sb", DW'(sb.size()), DW'(0));

    // Early pix_last on beat 2 of a 4-row window.
    w0 = wr_cnt;
    b0 = rnd();
    b1 = rnd();
    do_start(8'd4, 3'd1);
    send(b0, 1'b0, 0, 0, 1);
    send(b1, 1'b1, 1, 0, 1);
`ifdef REF_LOADER_PAD_EN
    push(2, 0, 1, b1, last_acc + 2);
    push(3, 0, 1, b1, last_acc + 3);
    exp_done = last_acc + 4;
    wait_done("early_pad_done_lat", exp_done);
    check("early_pad_writes", DW'(wr_cnt - w0), DW'(4));
`else
    exp_done = last_acc + 2;
    wait_done("early_done_lat", exp_done);
    check("early_writes", DW'(wr_cnt - w0), DW'(2));
`endif
    repeat (5) @(negedge clk);
    check("final_sb", DW'(sb.size()), DW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end
endmodule
